// File: rtl/pdp8_bus_pkg.sv
// Shared constants for the pdp8 bus slave: beat tags, status bit positions, FSM encoding.
package pdp8_bus_pkg;

  // Data-beat tags (cpu_out[6:5])
  localparam logic [1:0] TAG_DH  = 2'b00;
  localparam logic [1:0] TAG_DM  = 2'b01;
  localparam logic [1:0] TAG_DL  = 2'b10;
  localparam logic [1:0] TAG_IOI = 2'b11;

  // Status nibble bit positions returned on the IO intro beat
  localparam int ST_READY = 0;
  localparam int ST_SKIP  = 1;
  localparam int ST_INT   = 2;

  // FSM state = phase of the last accepted beat
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ALO  = 3'd1;
  localparam logic [2:0] S_AHI  = 3'd2;
  localparam logic [2:0] S_IOI  = 3'd3;
  localparam logic [2:0] S_DH   = 3'd4;
  localparam logic [2:0] S_DM   = 3'd5;
  localparam logic [2:0] S_DL   = 3'd6;

endpackage

// File: rtl/pdp8_bus_ram.sv
// 2**ADDR_W x 12 word store: synchronous write, registered read, contents never reset.
module pdp8_bus_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [11:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [11:0]       rdata
);

  logic [11:0] mem [0:(1<<ADDR_W)-1];

  // Write port and registered read port share the clock edge
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pdp8_bus_mem.sv
// Bus-side slave of the pdp8 core: decodes the 8-bit beat stream, serves memory
// beats from pdp8_bus_ram and forwards IO cycles to one device port.
// Optional feature: define PDP8_BUS_ERR_EN to add the sticky bus_err output.
module pdp8_bus_mem
  import pdp8_bus_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  cpu_out,
  output logic [3:0]  cpu_in,
  output logic [5:0]  io_dev,
  output logic [2:0]  io_fn,
  output logic [11:0] io_wdata,
  output logic        io_wr,
  output logic        io_rd,
  input  logic [11:0] io_rdata,
  input  logic        io_ready,
  input  logic        io_skip,
  input  logic        int_req
`ifdef PDP8_BUS_ERR_EN
  ,
  output logic        bus_err
`endif
);

  logic [2:0]        state, nxt;
  logic              legal;
  logic              is_addr, addr_hi, w;
  logic [1:0]        tag;
  logic [3:0]        d;
  logic [5:0]        alo;
  logic [ADDR_W-1:0] raddr, ram_addr;
  logic              is_io;
  logic [11:0]       io_word, ram_rdata, rword;
  logic [7:0]        wbuf;
  logic [1:0]        wmask;
  logic              commit;

  assign is_addr = cpu_out[7];
  assign addr_hi = cpu_out[6];
  assign tag     = cpu_out[6:5];
  assign w       = cpu_out[4];
  assign d       = cpu_out[3:0];

  // Bus addresses alias onto the low ADDR_W bits
  assign raddr  = ADDR_W'({cpu_out[5:0], alo});
  assign rword  = is_io ? io_word : ram_rdata;
  assign commit = legal && (nxt == S_DL) && w && (&wmask);

  // Next phase for the current beat; legal=0 marks an out-of-order beat
  always_comb begin
    legal = 1'b0;
    nxt   = S_IDLE;
    if (is_addr) begin
      if (!addr_hi) begin
        nxt   = S_ALO;
        legal = (state == S_IDLE) || (state == S_DL);
      end else if (state == S_ALO) begin
        nxt   = S_AHI;
        legal = 1'b1;
      end
    end else begin
      case (tag)
        TAG_IOI: if (state == S_AHI) begin nxt = S_IOI; legal = 1'b1; end
        TAG_DH:  if (state == S_AHI || state == S_IOI) begin nxt = S_DH; legal = 1'b1; end
        TAG_DM:  if (state == S_DH) begin nxt = S_DM; legal = 1'b1; end
        default: if (state == S_DM) begin nxt = S_DL; legal = 1'b1; end
      endcase
    end
  end

  // Nibble returned to the core for the beat currently on the bus
  always_comb begin
    cpu_in = 4'h0;
    if (legal && !is_addr) begin
      case (tag)
        TAG_DH:  cpu_in = rword[11:8];
        TAG_DM:  cpu_in = rword[7:4];
        TAG_DL:  cpu_in = rword[3:0];
        default: begin
          cpu_in[ST_READY] = io_ready;
          cpu_in[ST_SKIP]  = io_skip;
          cpu_in[ST_INT]   = int_req;
        end
      endcase
    end
  end

  // Beat sequencing, address/IO latches, write assembly and IO pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      alo      <= '0;
      ram_addr <= '0;
      is_io    <= 1'b0;
      io_word  <= '0;
      wbuf     <= '0;
      wmask    <= '0;
      io_dev   <= '0;
      io_fn    <= '0;
      io_wdata <= '0;
      io_wr    <= 1'b0;
      io_rd    <= 1'b0;
    end else begin
      state <= nxt;
      io_wr <= 1'b0;
      io_rd <= 1'b0;
      // A[5:0] beat is latched even when it resyncs a broken cycle
      if (is_addr && !addr_hi) alo <= cpu_out[5:0];
      if (legal && nxt == S_AHI) begin
        ram_addr <= raddr;
        is_io    <= 1'b0;
      end
      if (legal && nxt == S_IOI) begin
        is_io   <= 1'b1;
        io_word <= io_rdata;
        io_dev  <= alo;
        io_fn   <= d[2:0];
      end
      if (legal && nxt == S_DH) begin
        wmask[1] <= w;
        if (w) wbuf[7:4] <= d;
      end
      if (legal && nxt == S_DM) begin
        wmask[0] <= w;
        if (w) wbuf[3:0] <= d;
      end
      if (commit && is_io) begin
        io_wdata <= {wbuf, d};
        io_wr    <= 1'b1;
      end
      if (legal && nxt == S_DL && is_io && !w) io_rd <= 1'b1;
    end
  end

`ifdef PDP8_BUS_ERR_EN
  // Sticky flag for any resync or dropped beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus_err <= 1'b0;
    else if (!legal) bus_err <= 1'b1;
  end
`endif

  pdp8_bus_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (commit && !is_io),
    .waddr (ram_addr),
    .wdata ({wbuf, d}),
    .re    (legal && nxt == S_AHI),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

endmodule
